ex_div_ctrl: RTL and testbench

Iterative divider controller for the EX stage. It sequences a 33-bit restoring subtract-and-shift datapath over 32 cycles to implement DIV and DIVU. It returns a 64-bit {remainder, quotient} result for the HI/LO write path. It asserts a stall request so the pipeline holds the instruction in EX until the result is ready.

---
 rtl/ex_div_ctrl_if.sv | 24 ++
 rtl/ex_div_ctrl.sv | 114 +++++++++++
 tb/tb_ex_div_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_ctrl_if.sv
// EX-stage divider request/result bundle; the master drives operands and start/annul.
// No backpressure of its own: the slave answers with ready_o and holds the pipe via stallreq_o.
interface ex_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/ex_div_ctrl.sv
// Restoring DIV/DIVU sequencer, WIDTH cycles after the latching edge (one for divide-by-zero).
// Holds the result while start_i stays high; stallreq_o keeps EX frozen until it is ready.
module ex_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_ctrl_if.slave div
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     partial;
    logic [WIDTH-1:0]     dvd;
    logic [WIDTH-1:0]     dvs;
    logic                 q_neg;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;

    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic                 qbit;
    logic [WIDTH-1:0]     q_next;
    logic [WIDTH-1:0]     r_next;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 sgn1;
    logic                 sgn2;

    always_comb begin
        sgn1 = div.signed_div_i & div.opdata1_i[WIDTH-1];
        sgn2 = div.signed_div_i & div.opdata2_i[WIDTH-1];
        mag1 = sgn1 ? (~div.opdata1_i + 1'b1) : div.opdata1_i;
        mag2 = sgn2 ? (~div.opdata2_i + 1'b1) : div.opdata2_i;
        // 33-bit trial subtract: the sign bit decides keep vs restore
        shifted = {partial, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        qbit    = ~trial[WIDTH];
        q_next  = {dvd[WIDTH-2:0], qbit};
        r_next  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_fix   = q_neg ? (~q_next + 1'b1) : q_next;
        r_fix   = r_neg ? (~r_next + 1'b1) : r_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            partial <= '0;
            dvd     <= '0;
            dvs     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div.start_i && !div.annul_i) begin
                        if (div.opdata2_i == '0) begin
                            result <= '0;
                            ready  <= 1'b1;
                            state  <= DONE;
                        end else begin
                            dvd     <= mag1;
                            dvs     <= mag2;
                            q_neg   <= sgn1 ^ sgn2;
                            r_neg   <= sgn1;
                            partial <= '0;
                            cnt     <= '0;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (div.annul_i) begin
                        cnt    <= '0;
                        result <= '0;
                        ready  <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        partial <= r_next;
                        dvd     <= q_next;
                        cnt     <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            result <= {r_fix, q_fix};
                            ready  <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!div.start_i || div.annul_i) begin
                        result <= '0;
                        ready  <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div.result_o   = result;
    assign div.ready_o    = ready;
    assign div.stallreq_o = ((state == IDLE) && div.start_i && !div.annul_i) || (state == BUSY);
endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: driver pushes model results, monitor pops on ready_o rising.
// Covers the directed cases, annul, async reset and a randomized mix of operands.
module tb_ex_div_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] sb_q[$];
    logic ready_q = 1'b0;

    ex_div_ctrl_if #(.WIDTH(WIDTH)) dif ();

    ex_div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .div (dif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; x/0 is defined as 0.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && dif.ready_o && !ready_q) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", dif.result_o, 64'hx);
            end else begin
                chk("result", dif.result_o, sb_q.pop_front());
            end
            chk("stall_in_done", {63'd0, dif.stallreq_o}, 64'd0);
        end
        ready_q <= dif.ready_o;
    end

    task automatic raise_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.signed_div_i = s;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
    endtask

    // Counts posedges from the request cycle until ready_o; the latching edge counts as 1.
    task automatic wait_ready(output int lat, output int stl, output bit got);
        lat = 0;
        got = 1'b0;
        #1 stl = dif.stallreq_o ? 1 : 0;
        for (int k = 0; k < WIDTH + 8 && !got; k++) begin
            @(posedge clk);
            lat++;
            #1;
            dif.opdata1_i = $urandom;
            dif.opdata2_i = $urandom;
            @(negedge clk);
            if (dif.ready_o) got = 1'b1;
            else if (dif.stallreq_o) stl++;
        end
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int lat, stl;
        bit got;
        int exp_cyc;
        exp_cyc = (b == 32'd0) ? 1 : WIDTH + 1;
        sb_q.push_back(model(s, a, b));
        raise_start(s, a, b);
        wait_ready(lat, stl, got);
        chk("ready_timeout", {63'd0, got}, 64'd1);
        chk("latency", 64'(lat), 64'(exp_cyc));
        chk("stall_cycles", 64'(stl), 64'(exp_cyc));
        dif.start_i = 1'b0;
        @(negedge clk);
        chk("idle_ready", {63'd0, dif.ready_o}, 64'd0);
        chk("idle_result", dif.result_o, 64'd0);
    endtask

    initial begin
        int lat, stl, seen;
        bit got;
        logic s;
        logic [31:0] a, b;

        rst = 1'b1;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        #12;
        chk("rst_ready", {63'd0, dif.ready_o}, 64'd0);
        chk("rst_result", dif.result_o, 64'd0);
        chk("rst_stall", {63'd0, dif.stallreq_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        run_div(1'b0, 32'd5, 32'd0);
        run_div(1'b1, 32'h8000_0000, 32'h0000_0000);

        // Annul in the tenth BUSY cycle
        raise_start(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        dif.annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_stall", {63'd0, dif.stallreq_o}, 64'd0);
        chk("annul_ready", {63'd0, dif.ready_o}, 64'd0);
        @(negedge clk);
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        seen = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (dif.ready_o) seen++;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_div(1'b0, 32'd9, 32'd3);

        // Async reset mid-BUSY, away from any clock edge
        raise_start(1'b0, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #3;
        chk("busy_stall_before_rst", {63'd0, dif.stallreq_o}, 64'd1);
        rst = 1'b1;
        dif.start_i = 1'b0;
        #1;
        chk("arst_stall", {63'd0, dif.stallreq_o}, 64'd0);
        chk("arst_ready", {63'd0, dif.ready_o}, 64'd0);
        chk("arst_result", dif.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b0, 32'd100, 32'd7);

        // Async reset while holding a result in DONE
        sb_q.push_back(model(1'b1, 32'hFFFF_FF00, 32'd10));
        raise_start(1'b1, 32'hFFFF_FF00, 32'd10);
        wait_ready(lat, stl, got);
        chk("done_rst_timeout", {63'd0, got}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("done_arst_ready", {63'd0, dif.ready_o}, 64'd0);
        chk("done_arst_result", dif.result_o, 64'd0);
        dif.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_div(s, a, b);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
